// File: rtl/openram_bist_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : openram_bist_controller_if                                       |
// | Purpose : Shared port-0 SRAM bus between the BIST engine and the macros.   |
// |           All macros see the same addr0/din0/web0/wmask0 and have their    |
// |           own active-low chip select; read data comes back per macro.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface openram_bist_controller_if #(
  parameter int NUM_SRAMS = 16,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int WMASK_W   = 4
);
  logic [ADDR_W-1:0]           addr0;
  logic [DATA_W-1:0]           din0;
  logic                        web0;
  logic [WMASK_W-1:0]          wmask0;
  logic [NUM_SRAMS-1:0]        csb0;
  logic [NUM_SRAMS*DATA_W-1:0] dout_bus;

  // BIST side: drives the shared bus, receives every macro's read data
  modport master (output addr0, din0, web0, wmask0, csb0, input dout_bus);
  // Macro side
  modport slave  (input addr0, din0, web0, wmask0, csb0, output dout_bus);
endinterface
`default_nettype wire

// File: rtl/openram_bist_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : openram_bist_controller                                          |
// | Purpose : March C- / fill-readback BIST for one macro on a shared SRAM     |
// |           port-0 bus, with on-chip compare, saturating fail count and      |
// |           capture of the first failing address and data.                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module openram_bist_controller #(
  parameter int NUM_SRAMS = 16,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int WMASK_W   = 4,
  parameter int RD_LAT    = 2,
  parameter int FCNT_W    = 16,
  localparam int SEL_W    = (NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SEL_W-1:0]         sram_sel,
  input  logic                     mode,
  input  logic [ADDR_W-1:0]        depth_m1,
  input  logic [DATA_W-1:0]        pattern,
  openram_bist_controller_if.master sram,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [FCNT_W-1:0]        fail_count,
  output logic [ADDR_W-1:0]        first_fail_addr,
  output logic [DATA_W-1:0]        first_fail_data
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam int                   c_cnt_w     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [c_cnt_w-1:0]   c_drain_end = c_cnt_w'(RD_LAT - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
  localparam logic [ADDR_W-1:0]    c_addr_one  = ADDR_W'(1);
  localparam logic [FCNT_W-1:0]    c_fcnt_one  = FCNT_W'(1);
  localparam logic [SEL_W:0]       c_num_srams = (SEL_W + 1)'(NUM_SRAMS);
  localparam logic [NUM_SRAMS-1:0] c_csb_one   = NUM_SRAMS'(1);

  // Elements 0..5 = ^w0, ^r0w1, ^r1w0, vr0w1, vr1w0, ^r0; fill mode runs 0 then 5
  logic [1:0]         r_state, w_next_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_mode;
  logic [ADDR_W-1:0]  r_depth, r_addr;
  logic [DATA_W-1:0]  r_pat;
  logic [2:0]         r_elem, w_next_elem;
  logic               r_phase;
  logic [c_cnt_w-1:0] r_cnt;

  logic               r_pv   [RD_LAT];
  logic [DATA_W-1:0]  r_pexp [RD_LAT];
  logic [ADDR_W-1:0]  r_paddr[RD_LAT];

  logic w_is_rw, w_down, w_is_read, w_rd_one, w_wr_one, w_addr_end, w_last_op;
  logic w_start_ok, w_abort, w_mismatch;
  logic [DATA_W-1:0]    w_rdata;
  logic [NUM_SRAMS-1:0] w_csb0;
  logic [ADDR_W-1:0]    w_addr0;
  logic [DATA_W-1:0]    w_din0;
  logic                 w_web0;

  // Decode of the current march element and the op it issues this cycle
  always_comb begin
    w_is_rw     = (r_elem >= 3'd1) && (r_elem <= 3'd4);
    w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
    w_is_read   = (r_elem != 3'd0) && !r_phase;
    w_rd_one    = (r_elem == 3'd2) || (r_elem == 3'd4);
    w_wr_one    = (r_elem == 3'd1) || (r_elem == 3'd3);
    w_addr_end  = w_down ? (r_addr == '0) : (r_addr == r_depth);
    w_last_op   = (r_elem == 3'd5) && w_addr_end;
    w_next_elem = (r_elem == 3'd0 && r_mode) ? 3'd5 : 3'(r_elem + 3'd1);
    w_start_ok  = start && (r_state == c_st_idle || r_state == c_st_done) &&
                  ({1'b0, sram_sel} < c_num_srams);
    w_abort     = abort && (r_state == c_st_run || r_state == c_st_drain);
    w_rdata     = sram.dout_bus[r_sel*DATA_W +: DATA_W];
    w_mismatch  = r_pv[RD_LAT-1] && !w_abort && (w_rdata != r_pexp[RD_LAT-1]);
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= c_st_idle;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (w_start_ok) w_next_state = c_st_run;
      c_st_run:   if (w_abort) w_next_state = c_st_idle;
                  else if (w_last_op) w_next_state = c_st_drain;
      c_st_drain: if (w_abort) w_next_state = c_st_idle;
                  else if (r_cnt == c_drain_end) w_next_state = c_st_done;
      c_st_done:  if (w_start_ok) w_next_state = c_st_run;
      default:    w_next_state = c_st_idle;
    endcase
  end

  // Output logic: the bus is only active in RUN, and only the selected macro is enabled
  always_comb begin
    w_csb0  = '1;
    w_web0  = 1'b1;
    w_addr0 = '0;
    w_din0  = '0;
    if (r_state == c_st_run) begin
      w_csb0  = ~(c_csb_one << r_sel);
      w_web0  = w_is_read;
      w_addr0 = r_addr;
      if (!w_is_read) w_din0 = w_wr_one ? ~r_pat : r_pat;
    end
    busy = (r_state == c_st_run) || (r_state == c_st_drain);
    done = (r_state == c_st_done);
    pass = done && (fail_count == '0);
  end

  assign sram.csb0   = w_csb0;
  assign sram.web0   = w_web0;
  assign sram.addr0  = w_addr0;
  assign sram.din0   = w_din0;
  assign sram.wmask0 = '1;

  // Test configuration latch and address/element sequencing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sel <= '0; r_mode <= 1'b0; r_depth <= '0; r_pat <= '0;
      r_elem <= 3'd0; r_phase <= 1'b0; r_addr <= '0; r_cnt <= '0;
    end else begin
      r_cnt <= (r_state == c_st_drain) ? c_cnt_w'(r_cnt + c_cnt_one) : '0;
      if (w_start_ok) begin
        r_sel <= sram_sel; r_mode <= mode; r_depth <= depth_m1; r_pat <= pattern;
        r_elem <= 3'd0; r_phase <= 1'b0; r_addr <= '0;
      end else if (r_state == c_st_run && !w_abort) begin
        if (w_is_rw && !r_phase) begin
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_addr_end) begin
            r_elem <= w_next_elem;
            r_addr <= (w_next_elem == 3'd3 || w_next_elem == 3'd4) ? r_depth : '0;
          end else begin
            r_addr <= w_down ? (r_addr - c_addr_one) : (r_addr + c_addr_one);
          end
        end
      end
    end
  end

  // Read-compare pipe: each read carries its expected word and address for RD_LAT cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0; r_pexp[i] <= '0; r_paddr[i] <= '0;
      end
    end else begin
      r_pv[0]    <= (r_state == c_st_run) && w_is_read && !w_abort;
      r_pexp[0]  <= w_rd_one ? ~r_pat : r_pat;
      r_paddr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1]; r_pexp[i] <= r_pexp[i-1]; r_paddr[i] <= r_paddr[i-1];
      end
      if (w_abort) for (int i = 0; i < RD_LAT; i++) r_pv[i] <= 1'b0;
    end
  end

  // Result capture; a zero count means no mismatch yet since start (the count never wraps)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fail_count <= '0; first_fail_addr <= '0; first_fail_data <= '0;
    end else if (w_start_ok) begin
      fail_count <= '0; first_fail_addr <= '0; first_fail_data <= '0;
    end else if (w_mismatch) begin
      if (fail_count == '0) begin
        first_fail_addr <= r_paddr[RD_LAT-1];
        first_fail_data <= w_rdata;
      end
      if (fail_count != '1) fail_count <= fail_count + c_fcnt_one;
    end
  end

endmodule
`default_nettype wire
